// File: rtl/power_domain_sequencer.sv
// Round-robin power sequencer: walks one gated domain at a time through power/iso/clock/reset steps.
// Optional PSEQ_RETENTION_EN adds a retention enable per domain and a DN_RET step on power-down.
module power_domain_sequencer #(
    parameter int  NUM_DOMAINS     = 4,
    parameter int  PWR_UP_CYCLES   = 8,
    parameter int  RST_HOLD_CYCLES = 2,
    localparam int DW              = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DOMAINS-1:0] pwr_req,
    output logic [NUM_DOMAINS-1:0] pwr_en,
    output logic [NUM_DOMAINS-1:0] iso_en,
    output logic [NUM_DOMAINS-1:0] clk_en,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic [NUM_DOMAINS-1:0] pwr_ack,
    output logic                   busy,
`ifdef PSEQ_RETENTION_EN
    output logic [NUM_DOMAINS-1:0] ret_en,
`endif
    output logic [DW-1:0]          cur_dom
);

    typedef enum logic [2:0] {
        IDLE,
        UP_PWR,
        UP_ISO,
        UP_RST,
        DN_CLK,
`ifdef PSEQ_RETENTION_EN
        DN_RET,
`endif
        DN_ISO,
        DN_PWR
    } state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [DW-1:0]        last_served;
    logic [NUM_DOMAINS-1:0] pending;
    logic                 sel_found;
    logic [DW-1:0]        sel_dom;

    // Round-robin search starting just after the last served domain.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pending   = pwr_req ^ pwr_ack;
        sel_found = 1'b0;
        sel_dom   = '0;
        for (int k = 1; k <= NUM_DOMAINS; k++) begin
            int idx;
            idx = int'(last_served) + k;
            if (idx >= NUM_DOMAINS) idx = idx - NUM_DOMAINS;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_dom   = DW'(idx);
            end
        end
    end

    // NOTE: all state and outputs are registered with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_served <= DW'(NUM_DOMAINS - 1);
            cur_dom     <= '0;
            busy        <= 1'b0;
            pwr_en      <= '0;
            iso_en      <= '1;
            clk_en      <= '0;
            dom_rst_n   <= '0;
            pwr_ack     <= '0;
`ifdef PSEQ_RETENTION_EN
            ret_en      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        cur_dom     <= sel_dom;
                        last_served <= sel_dom;
                        busy        <= 1'b1;
                        if (pwr_req[sel_dom]) begin
                            pwr_en[sel_dom] <= 1'b1;
                            cnt             <= 8'(PWR_UP_CYCLES - 1);
                            state           <= UP_PWR;
                        end else begin
                            clk_en[sel_dom]    <= 1'b0;
                            dom_rst_n[sel_dom] <= 1'b0;
                            state              <= DN_CLK;
                        end
                    end
                end
                UP_PWR: begin
                    if (cnt == 8'd0) begin
                        iso_en[cur_dom] <= 1'b0;
`ifdef PSEQ_RETENTION_EN
                        ret_en[cur_dom] <= 1'b0;
`endif
                        state           <= UP_ISO;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                UP_ISO: begin
                    clk_en[cur_dom] <= 1'b1;
                    cnt             <= 8'(RST_HOLD_CYCLES - 1);
                    state           <= UP_RST;
                end
                UP_RST: begin
                    if (cnt == 8'd0) begin
                        dom_rst_n[cur_dom] <= 1'b1;
                        pwr_ack[cur_dom]   <= 1'b1;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef PSEQ_RETENTION_EN
                DN_CLK: begin
                    ret_en[cur_dom] <= 1'b1;
                    state           <= DN_RET;
                end
                DN_RET: begin
                    iso_en[cur_dom] <= 1'b1;
                    state           <= DN_ISO;
                end
`else
                DN_CLK: begin
                    iso_en[cur_dom] <= 1'b1;
                    state           <= DN_ISO;
                end
`endif
                // DN_PWR is never entered; it shares the final power-off step for safety.
                DN_ISO, DN_PWR: begin
                    pwr_en[cur_dom]  <= 1'b0;
                    pwr_ack[cur_dom] <= 1'b0;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer with default parameters (4 domains, 8 settle, 2 hold).
module tb_power_domain_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pwr_req;
    logic [3:0] pwr_en, iso_en, clk_en, dom_rst_n, pwr_ack;
    logic       busy;
    logic [1:0] cur_dom;
`ifdef PSEQ_RETENTION_EN
    logic [3:0] ret_en;
`endif

    int checks = 0;
    int errors = 0;

    power_domain_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req   (pwr_req),
        .pwr_en    (pwr_en),
        .iso_en    (iso_en),
        .clk_en    (clk_en),
        .dom_rst_n (dom_rst_n),
        .pwr_ack   (pwr_ack),
        .busy      (busy),
`ifdef PSEQ_RETENTION_EN
        .ret_en    (ret_en),
`endif
        .cur_dom   (cur_dom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] req);
        rst_n   = 1'b0;
        pwr_req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        pwr_req = req;
    endtask

    task automatic wait_busy(input string tag, input logic val, input int budget);
        for (int i = 0; i < budget && busy !== val; i++) step();
        check(tag, busy, val);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pwr_en"}, pwr_en, 4'b0000);
        check({tag, "_iso_en"}, iso_en, 4'b1111);
        check({tag, "_clk_en"}, clk_en, 4'b0000);
        check({tag, "_dom_rst_n"}, dom_rst_n, 4'b0000);
        check({tag, "_pwr_ack"}, pwr_ack, 4'b0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cur_dom"}, cur_dom, 2'd0);
    endtask

    initial begin
        int nexp;
        logic prev_busy;

        // Reset values
        rst_n   = 1'b0;
        pwr_req = 4'b0000;
        #12;
        check_reset_outputs("rst");

        // Domain 0 power-up: pwr_en at E0, iso off at E0+8, clk at E0+9, rst/ack at E0+11
        @(negedge clk);
        rst_n   = 1'b1;
        pwr_req = 4'b0001;
        step();
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("up0_pwr_en_k%0d", k), pwr_en, 4'b0001);
            check($sformatf("up0_iso_k%0d", k), iso_en, (k < 8) ? 4'b1111 : 4'b1110);
            check($sformatf("up0_clk_k%0d", k), clk_en, (k >= 9) ? 4'b0001 : 4'b0000);
            check($sformatf("up0_rst_k%0d", k), dom_rst_n, (k >= 11) ? 4'b0001 : 4'b0000);
            check($sformatf("up0_ack_k%0d", k), pwr_ack, (k >= 11) ? 4'b0001 : 4'b0000);
            check($sformatf("up0_busy_k%0d", k), busy, (k <= 10) ? 1'b1 : 1'b0);
            step();
        end

        // Domain 0 power-down: clk/rst off at E0, iso at E0+1, power/ack off at E0+2
        pwr_req = 4'b0000;
        step();
        check("dn0_e0_clk", clk_en, 4'b0000);
        check("dn0_e0_rst", dom_rst_n, 4'b0000);
        check("dn0_e0_iso", iso_en, 4'b1110);
        check("dn0_e0_busy", busy, 1'b1);
        step();
        check("dn0_e1_iso", iso_en, 4'b1111);
        check("dn0_e1_pwr", pwr_en, 4'b0001);
        step();
        check("dn0_e2_pwr", pwr_en, 4'b0000);
        check("dn0_e2_ack", pwr_ack, 4'b0000);
        check("dn0_e2_busy", busy, 1'b0);

        // All four requested at once: served 0,1,2,3, one at a time, with an IDLE gap
        do_reset(4'b1111);
        nexp      = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 200 && !(pwr_ack == 4'b1111 && !busy); c++) begin
            step();
            if (busy && !prev_busy) begin
                check("rr_order", cur_dom, nexp[1:0]);
                nexp++;
            end
            check("rr_overlap", $countones(pwr_en ^ pwr_ack) <= 1, 1'b1);
            prev_busy = busy;
        end
        check("rr_count", nexp, 4);
        check("rr_final_ack", pwr_ack, 4'b1111);

        // Domain 2 request pulsed during power-up: up completes, then a power-down follows
        do_reset(4'b0100);
        step();
        check("pulse_sel", cur_dom, 2'd2);
        check("pulse_pwr_en", pwr_en, 4'b0100);
        step();
        step();
        pwr_req = 4'b0000;
        wait_busy("pulse_up_done", 1'b0, 20);
        check("pulse_up_ack", pwr_ack, 4'b0100);
        wait_busy("pulse_dn_start", 1'b1, 5);
        check("pulse_dn_dom", cur_dom, 2'd2);
        wait_busy("pulse_dn_done", 1'b0, 10);
        check("pulse_dn_ack", pwr_ack, 4'b0000);
        check("pulse_dn_pwr", pwr_en, 4'b0000);

        // Reset mid power-up aborts at once; held request restarts from UP_PWR
        do_reset(4'b0001);
        step();
        for (int k = 0; k < 5; k++) step();
        check("abort_pre_pwr", pwr_en, 4'b0001);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("restart_busy", busy, 1'b1);
        check("restart_pwr_en", pwr_en, 4'b0001);
        check("restart_iso", iso_en, 4'b1111);
        for (int k = 0; k < 8; k++) step();
        check("restart_iso_e8", iso_en, 4'b1110);
        check("restart_clk_e8", clk_en, 4'b0000);

`ifdef PSEQ_RETENTION_EN
        // Retention: domain 1 down sets ret_en at E0+1; up clears it with iso at E0+8
        do_reset(4'b0010);
        wait_busy("ret_up_start", 1'b1, 5);
        wait_busy("ret_up_done", 1'b0, 20);
        check("ret_up_ack", pwr_ack, 4'b0010);
        check("ret_up_ret", ret_en, 4'b0000);
        pwr_req = 4'b0000;
        step();
        check("ret_dn_e0_ret", ret_en, 4'b0000);
        check("ret_dn_e0_clk", clk_en, 4'b0000);
        step();
        check("ret_dn_e1_ret", ret_en, 4'b0010);
        check("ret_dn_e1_iso", iso_en, 4'b1101);
        step();
        check("ret_dn_e2_iso", iso_en, 4'b1111);
        check("ret_dn_e2_pwr", pwr_en, 4'b0010);
        step();
        check("ret_dn_e3_pwr", pwr_en, 4'b0000);
        check("ret_dn_e3_ack", pwr_ack, 4'b0000);
        step();
        pwr_req = 4'b0010;
        step();
        check("ret_re_e0_ret", ret_en, 4'b0010);
        for (int k = 0; k < 7; k++) step();
        check("ret_re_e7_ret", ret_en, 4'b0010);
        check("ret_re_e7_iso", iso_en, 4'b1111);
        step();
        check("ret_re_e8_ret", ret_en, 4'b0000);
        check("ret_re_e8_iso", iso_en, 4'b1101);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_domain_sequencer.md
POWER_DOMAIN_SEQUENCER -- requirements
Module: power_domain_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4, number of gated domains (1..16).
REQ-002 SHALL have parameter PWR_UP_CYCLES, default 8, power-settle wait in cycles (1..255).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 2, cycles domain reset is held after the clock is enabled (1..255).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pwr_req  input  NUM_DOMAINS  per-domain target state, level (1 = on).
REQ-007 SHALL have port pwr_en  output  NUM_DOMAINS  power switch enable.
REQ-008 SHALL have port iso_en  output  NUM_DOMAINS  output isolation enable (1 = isolated).
REQ-009 SHALL have port clk_en  output  NUM_DOMAINS  clock-gate enable.
REQ-010 SHALL have port dom_rst_n  output  NUM_DOMAINS  domain reset, active-low.
REQ-011 SHALL have port pwr_ack  output  NUM_DOMAINS  status (1 = domain fully on).
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port cur_dom  output  $clog2(NUM_DOMAINS) (min 1)  domain being sequenced.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 Domain i SHALL be pending when pwr_req[i] != pwr_ack[i].
REQ-016 States SHALL be IDLE, UP_PWR, UP_ISO, UP_RST, DN_CLK, DN_ISO, DN_PWR.
REQ-017 Only one domain SHALL be sequenced at a time.
REQ-018 In IDLE with any domain pending, at edge E0 the block SHALL select the first pending domain in round-robin order starting at last_served+1 (mod NUM_DOMAINS). It SHALL latch the selection into cur_dom and last_served, set busy=1, and go to UP_PWR if pwr_req[d]=1, else DN_CLK.
REQ-019 Power-up timing:
- At E0: pwr_en[d]=1.
- At E0+PWR_UP_CYCLES: iso_en[d]=0; state goes to UP_ISO.
- At E0+PWR_UP_CYCLES+1: clk_en[d]=1; state goes to UP_RST.
- At E0+PWR_UP_CYCLES+1+RST_HOLD_CYCLES: dom_rst_n[d]=1, pwr_ack[d]=1, busy=0; state goes to IDLE.
REQ-020 Power-down timing:
- At E0: clk_en[d]=0, dom_rst_n[d]=0.
- At E0+1: iso_en[d]=1.
- At E0+2: pwr_en[d]=0, pwr_ack[d]=0, busy=0; state goes to IDLE.
REQ-021 A started sequence SHALL run to completion regardless of pwr_req changes. A reversed request SHALL simply be pending again afterwards.
REQ-022 After returning to IDLE, the block SHALL spend at least one cycle in IDLE before the next selection.
REQ-023 Outputs of non-selected domains SHALL hold their values.
REQ-024 The wait counter SHALL be 8 bits, load at each timed-state entry, and never wrap.

Reset
REQ-025 On rst_n low, asynchronously:
- pwr_en=0, iso_en=all ones, clk_en=0, dom_rst_n=0, pwr_ack=0.
- busy=0, cur_dom=0, state=IDLE, last_served=NUM_DOMAINS-1, counter=0.
REQ-026 Reset mid-sequence SHALL abort the sequence immediately with no partial state retained.
REQ-027 After rst_n rises, the first selection SHALL occur at the first edge with a pending domain, with domain 0 winning ties.

Configuration
REQ-028 Macro PSEQ_RETENTION_EN SHALL add output ret_en [NUM_DOMAINS] (retention save/hold), reset 0.
- Power-down: a state DN_RET is inserted after DN_CLK. ret_en[d]=1 at E0+1, iso at E0+2, pwr_en/pwr_ack fall at E0+3.
- Power-up: ret_en[d]=0 at the same edge iso_en[d] falls.
REQ-029 Without PSEQ_RETENTION_EN, port ret_en and state DN_RET SHALL be absent and timing SHALL be exactly per REQ-019/REQ-020.

Verification
REQ-030 Defaults, after reset: pwr_req=4'b0001 -> pwr_en[0] rises at E0, iso_en[0] falls at E0+8, clk_en[0] rises at E0+9, dom_rst_n[0] and pwr_ack[0] rise at E0+11; busy high E0..E0+10.
REQ-031 Domain 0 on, then pwr_req=4'b0000 -> clk_en[0]=0 at E0, iso_en[0]=1 at E0+1, pwr_en[0]=0 and pwr_ack[0]=0 at E0+2.
REQ-032 After reset, pwr_req=4'b1111 in one cycle -> domains served in order 0,1,2,3, with no overlap, each separated by at least one IDLE cycle; final pwr_ack=4'b1111.
REQ-033 pwr_req[2] pulsed 1 for 3 cycles during domain 2 power-up -> up completes (pwr_ack[2]=1), then a power-down runs, ending with pwr_ack[2]=0.
REQ-034 rst_n low at E0+5 of a power-up -> all outputs at reset values in the same cycle; with pwr_req held, the sequence restarts from UP_PWR after release.
REQ-035 With PSEQ_RETENTION_EN, power-down of domain 1 -> ret_en[1]=1 at E0+1, iso_en[1]=1 at E0+2, pwr_en[1]=0 at E0+3; power-up clears ret_en[1] with iso_en[1] at E0+8.
